rob_controller: RTL
===================

ROB_CONTROLLER -- requirements
Module: rob_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8, result data width.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have disp_valid  input  1  decode offers an instruction with a destination register.
REQ-005 SHALL have disp_dest  input  3  architectural destination register of offered instruction.
REQ-006 SHALL have disp_ready  output  1  controller can accept a dispatch this cycle.
REQ-007 SHALL have wb_valid  input  1  execution unit result strobe.
REQ-008 SHALL have wb_rob_idx  input  2  ROB entry the result belongs to.
REQ-009 SHALL have wb_data  input  DATA_W  result value.
REQ-010 SHALL have rat_update_en  output  1  rename-table update strobe (new mapping).
REQ-011 SHALL have rat_dest_reg  output  3  register being renamed.
REQ-012 SHALL have rat_rob_tail  output  2  ROB index allocated to that register.
REQ-013 SHALL have rat_commit_en  output  1  rename-table clear strobe for committed register.
REQ-014 SHALL have rat_commit_reg  output  3  register whose mapping is cleared.
REQ-015 SHALL have commit_valid  output  1  head entry retires this cycle (register-file write).
REQ-016 SHALL have commit_reg  output  3  architectural register written at retire.
REQ-017 SHALL have commit_data  output  DATA_W  value written at retire.
REQ-018 SHALL have commit_rob_idx  output  2  index of retiring entry.
REQ-019 SHALL have occupancy  output  3  valid entries, 0..4.

Function
REQ-020 SHALL hold 4 entries {valid, done, dest[2:0], data[DATA_W-1:0]}, head and tail 2-bit pointers, 3-bit count.
REQ-021 SHALL drive disp_ready = (count != 4); no same-cycle bypass of a retiring entry when full.
REQ-022 SHALL define dispatch fire = disp_valid && disp_ready; rat_update_en = fire, rat_dest_reg = disp_dest, rat_rob_tail = tail, all combinational, same cycle.
REQ-023 On fire, at the clock edge, SHALL set entry[tail] valid=1, done=0, dest=disp_dest, and increment tail modulo 4.
REQ-024 On wb_valid with entry[wb_rob_idx].valid=1, SHALL set done=1 and data=wb_data at the edge; wb to an invalid entry SHALL be ignored.
REQ-025 SHALL drive commit_valid = entry[head].valid && entry[head].done, combinationally; commit_reg/commit_data/commit_rob_idx from entry[head]; a result written back in cycle N retires no earlier than cycle N+1.
REQ-026 On commit_valid, at the edge, SHALL clear entry[head].valid and increment head modulo 4; at most one retire per cycle.
REQ-027 SHALL drive rat_commit_en = commit_valid && no other valid entry has dest == entry[head].dest; rat_commit_reg = entry[head].dest.
REQ-028 Same-cycle dispatch to the retiring register SHALL NOT suppress rat_commit_en (rename table gives update priority).
REQ-029 Count SHALL update count + fire - commit_valid; simultaneous fire and commit leaves count unchanged; occupancy = count.
REQ-030 Simultaneous wb and commit on different entries SHALL both take effect; wb to the retiring head is a no-op because done is already 1.
REQ-031 Pointers SHALL wrap 3->0 with no other effect; full (count=4) and empty (count=0) SHALL be distinguished by count only.
REQ-032 All strobe outputs SHALL be 0 whenever their enabling condition is false; data outputs don't-care then.

Reset
REQ-033 rst_n low SHALL immediately clear all valid/done bits, head=tail=0, count=0, independent of clk.
REQ-034 During and after reset, until first event: disp_ready=1, occupancy=0, rat_update_en=0, rat_commit_en=0, commit_valid=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; no commit after deassert without new dispatch and wb.

Verification
REQ-036 Dispatch dest=3 from reset -> rat_update_en=1, rat_rob_tail=0 same cycle; next cycle occupancy=1.
REQ-037 Dispatch r1,r2,r3,r4; wb idx 0 data 0x5A -> next cycle commit_valid=1, commit_reg=1, commit_data=0x5A, rat_commit_en=1; disp_ready=0 while count=4.
REQ-038 Dispatch r5 twice (idx 0,1); wb idx 0 -> commit of idx 0 with rat_commit_en=0; then wb idx 1 -> commit with rat_commit_en=1, rat_commit_reg=5.
REQ-039 Out-of-order wb: wb idx 1 then idx 0 -> retire order idx 0 then idx 1 on consecutive cycles.
REQ-040 Full ROB with head done, disp_valid=1 -> disp_ready=0, commit same cycle; next cycle count=3, dispatch accepted, tail wraps to 0.
REQ-041 Assert rst_n low with 3 entries in flight between edges -> outputs at reset values immediately; wb after release ignored, commit_valid stays 0.

Source files
------------

// File: rtl/rob_controller.sv
// Four-entry reorder buffer: in-order dispatch, out-of-order writeback, in-order retire.
// Drives rename-table update/clear strobes and the register-file commit port.
module rob_controller #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_valid,
    input  logic [2:0]        disp_dest,
    output logic              disp_ready,
    input  logic              wb_valid,
    input  logic [1:0]        wb_rob_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rat_update_en,
    output logic [2:0]        rat_dest_reg,
    output logic [1:0]        rat_rob_tail,
    output logic              rat_commit_en,
    output logic [2:0]        rat_commit_reg,
    output logic              commit_valid,
    output logic [2:0]        commit_reg,
    output logic [DATA_W-1:0] commit_data,
    output logic [1:0]        commit_rob_idx,
    output logic [2:0]        occupancy
);

    logic [3:0]        r_valid;
    logic [3:0]        r_done;
    logic [2:0]        r_dest [4];
    logic [DATA_W-1:0] r_data [4];
    logic [1:0]        r_head;
    logic [1:0]        r_tail;
    logic [2:0]        r_count;

    logic w_fire;
    logic w_commit;
    logic w_wb_ok;
    logic w_alias;

    assign disp_ready = (r_count != 3'd4);
    assign w_fire     = disp_valid && disp_ready;
    assign w_commit   = r_valid[r_head] && r_done[r_head];
    // a result aimed at the retiring head changes nothing: it is already done
    assign w_wb_ok    = wb_valid && r_valid[wb_rob_idx] && !(w_commit && (wb_rob_idx == r_head));

    // a younger in-flight writer of the same register keeps the rename mapping alive
    always_comb begin
        w_alias = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) != r_head) && r_valid[i] && (r_dest[i] == r_dest[r_head]))
                w_alias = 1'b1;
        end
    end

    assign rat_update_en  = w_fire;
    assign rat_dest_reg   = disp_dest;
    assign rat_rob_tail   = r_tail;
    assign rat_commit_en  = w_commit && !w_alias;
    assign rat_commit_reg = r_dest[r_head];
    assign commit_valid   = w_commit;
    assign commit_reg     = r_dest[r_head];
    assign commit_data    = r_data[r_head];
    assign commit_rob_idx = r_head;
    assign occupancy      = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0;
            r_done  <= 4'b0;
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_dest[i] <= 3'd0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_wb_ok) begin
                r_done[wb_rob_idx] <= 1'b1;
                r_data[wb_rob_idx] <= wb_data;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + 2'd1;
            end
            if (w_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_dest[r_tail]  <= disp_dest;
                r_tail          <= r_tail + 2'd1;
            end
            r_count <= r_count + {2'b00, w_fire} - {2'b00, w_commit};
        end
    end

endmodule
